// File: rtl/cgra_config_loader.sv
// Configuration loader for the CGRA serial config chain: holds the fabric in
// sync reset, streams host words MSB-first onto the chain, then enables the
// fabric once exactly TOTAL_NUM_BITS bits have been shifted.
module cgra_config_loader #(
  parameter int TOTAL_NUM_BITS = 816,
  parameter int WORD_WIDTH     = 32,
  parameter int RESET_CYCLES   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_bitstream,
  output logic                  config_enable,
  output logic                  cgra_sync_reset,
  output logic                  cgra_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int BCW = $clog2(TOTAL_NUM_BITS + 1);
  localparam int CCW = $clog2(RESET_CYCLES + 1);
  localparam int HW  = $clog2(WORD_WIDTH + 1);

  localparam logic [BCW-1:0] BIT_LAST = BCW'(TOTAL_NUM_BITS);
  localparam logic [CCW-1:0] CYC_LAST = CCW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RESET, LOAD, DONE} state_t;

  state_t                state;
  logic [BCW-1:0]        bit_cnt;   // bits already driven onto the chain
  logic [CCW-1:0]        cyc_cnt;   // sync-reset cycles elapsed
  logic [HW-1:0]         held;      // bits in sr not yet driven onto the chain
  logic [WORD_WIDTH-1:0] sr;        // next bit to drive is always sr[MSB]

  logic [31:0]    committed;
  logic [31:0]    avail;
  logic [HW-1:0]  bits_new;
  logic           accept;

  // Bits already driven or queued decide whether another word is wanted and
  // how much of it is real chain data (the final word may be truncated).
  always_comb begin
    committed  = 32'(bit_cnt) + 32'(held);
    avail      = 32'(TOTAL_NUM_BITS) - committed;
    bits_new   = (avail >= 32'(WORD_WIDTH)) ? HW'(WORD_WIDTH) : HW'(avail);
    word_ready = (state == LOAD) && !abort && (held <= HW'(1)) &&
                 (committed < 32'(TOTAL_NUM_BITS));
    accept     = word_valid && word_ready;
  end

  // Sequencer: IDLE -> RESET -> LOAD -> DONE, with registered chain/fabric pins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      cyc_cnt          <= '0;
      held             <= '0;
      sr               <= '0;
      config_bitstream <= 1'b0;
      config_enable    <= 1'b0;
      cgra_sync_reset  <= 1'b0;
      cgra_enable      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else if (abort) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      cyc_cnt          <= '0;
      held             <= '0;
      sr               <= '0;
      config_bitstream <= 1'b0;
      config_enable    <= 1'b0;
      cgra_sync_reset  <= 1'b0;
      cgra_enable      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RESET;
            cyc_cnt         <= '0;
            cgra_sync_reset <= 1'b1;
            cgra_enable     <= 1'b0;
            busy            <= 1'b1;
            done            <= 1'b0;
          end
        end
        RESET: begin
          if (cyc_cnt == CYC_LAST) begin
            state           <= LOAD;
            cgra_sync_reset <= 1'b0;
            bit_cnt         <= '0;
            held            <= '0;
            sr              <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        LOAD: begin
          if (bit_cnt == BIT_LAST) begin
            // Last bit was on the pins during the previous cycle.
            state            <= DONE;
            busy             <= 1'b0;
            done             <= 1'b1;
            cgra_enable      <= 1'b1;
            config_enable    <= 1'b0;
            config_bitstream <= 1'b0;
          end else begin
            if (held != '0 || accept) begin
              config_enable <= 1'b1;
              bit_cnt       <= bit_cnt + 1'b1;
            end else begin
              config_enable    <= 1'b0;
              config_bitstream <= 1'b0;
            end
            if (accept) begin
              // Empty: new MSB goes straight out. One bit left: drain it and
              // park the new word so its MSB follows with no gap.
              if (held == '0) begin
                config_bitstream <= word_data[WORD_WIDTH-1];
                sr               <= {word_data[WORD_WIDTH-2:0], 1'b0};
              end else begin
                config_bitstream <= sr[WORD_WIDTH-1];
                sr               <= word_data;
              end
              held <= held + bits_new - 1'b1;
            end else if (held != '0) begin
              config_bitstream <= sr[WORD_WIDTH-1];
              sr               <= {sr[WORD_WIDTH-2:0], 1'b0};
              held             <= held - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cgra_config_loader.md
Name: cgra_config_loader

Overview:
- Sequences configuration of the CGRA fabric's serial configuration chain, plus the fabric's enable after configuration.
- Accepts configuration words from a host or DMA over a valid/ready stream and serializes them, MSB first, onto the chain's bitstream/enable pins.
- Counts exactly TOTAL_NUM_BITS bits, then releases the fabric to run.
- Sits between the host interface and the CGRA top-level configuration pins.

Parameters:
- TOTAL_NUM_BITS, 816, length of the fabric configuration chain in bits (>= 1)
- WORD_WIDTH, 32, width of host configuration words (>= 2)
- RESET_CYCLES, 4, cycles cgra_sync_reset is held high before loading (>= 1)

Ports:
- clock  input  1  single clock; all logic on posedge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  pulse: begin a configuration sequence (honoured in IDLE or DONE only)
- abort  input  1  level: return to IDLE from any state next cycle
- word_data  input  WORD_WIDTH  configuration word; bit WORD_WIDTH-1 is shifted first
- word_valid  input  1  word_data valid
- word_ready  output  1  loader accepts word this cycle
- config_bitstream  output  1  serial bit to chain
- config_enable  output  1  chain shifts config_bitstream this cycle
- cgra_sync_reset  output  1  synchronous reset to fabric and chain
- cgra_enable  output  1  fabric run enable
- busy  output  1  high in RESET or LOAD
- done  output  1  high in DONE

Behaviour:
- Async reset (reset_n=0):
  - state=IDLE
  - all outputs 0; counters 0; shift register 0
- States and transitions:
  - IDLE -> RESET on start.
  - RESET:
    - cgra_sync_reset=1 for exactly RESET_CYCLES cycles, counted by a cycle counter.
    - Then -> LOAD; bit counter = 0.
  - LOAD:
    - word_ready=1 when the shift register holds 0 or 1 unshifted bits, and bits remaining in the chain > bits still in the shift register.
    - Handshake: a word is accepted on a cycle where word_valid & word_ready.
    - On accept, the shift register loads word_data. The next cycle drives config_bitstream=word_data[WORD_WIDTH-1] with config_enable=1, and so on down one bit per cycle.
    - Back-to-back words produce a gap-free bit stream.
    - Bubbles: when the shift register is empty and no word has been accepted, config_enable=0 and config_bitstream=0. The chain holds; no bit is counted.
    - The bit counter increments on every cycle with config_enable=1.
    - Final word: only the top (TOTAL_NUM_BITS mod WORD_WIDTH) bits are shifted, or the full word if the remainder is 0. The remaining low bits are discarded.
    - Word count = ceil(TOTAL_NUM_BITS/WORD_WIDTH). No word_ready after the final word is accepted.
    - The cycle after the last bit is shifted -> DONE.
  - DONE:
    - done=1, cgra_enable=1; config_enable=0.
    - start -> RESET: cgra_enable drops, cgra_sync_reset rises next cycle.
- abort:
  - Any state -> IDLE next cycle with all outputs 0; partial word discarded.
  - abort has priority over start on the same cycle.
- start while busy: ignored.
- word_valid outside LOAD: ignored; word_ready=0.
- Outputs are registered: config_bitstream, config_enable, cgra_sync_reset, cgra_enable, done, busy.
- Counter widths:
  - Bit counter: clog2(TOTAL_NUM_BITS+1).
  - Cycle counter: clog2(RESET_CYCLES+1).
  - In-word counter: clog2(WORD_WIDTH+1).
  - None wrap; they saturate at their terminal values.
- Minimum start-to-done latency with word_valid held high: 1 + RESET_CYCLES + 1 + TOTAL_NUM_BITS cycles.
  - Defaults: 822 cycles.

Test Plan:
- Reset, then start with 26 words, word_valid always high, default parameters.
  - cgra_sync_reset high exactly 4 cycles.
  - Exactly 816 config_enable cycles.
  - Captured stream equals concatenated word MSBs, last word top 16 bits only.
  - done at cycle 822; word_ready never high after the 26th accept.
- Random word_valid gaps (50% duty).
  - config_enable=0 during every bubble.
  - Identical 816-bit captured stream; done asserted; no word lost or duplicated.
- abort asserted after 300 bits shifted.
  - Next cycle: IDLE, all outputs 0.
  - Subsequent start reloads from bit 0 and yields the correct full stream.
- Restart from DONE.
  - cgra_enable falls on the start cycle's next edge, followed by 4 reset cycles and a full reload.
  - start pulses during LOAD are ignored.
- reset_n asserted mid-LOAD, asynchronously between clock edges.
  - All outputs 0 immediately; state IDLE after release.
- Parameter sweep: TOTAL_NUM_BITS=64, WORD_WIDTH=32 (remainder 0 -> 2 full words); TOTAL_NUM_BITS=1 (1 word, only its MSB shifted).
  - Bit counts and done timing match the latency formula.
